// File: rtl/asp_irq_ctrl_pkg.sv
// Shared definitions for the ASP interrupt aggregator: BSP line map, CSR word
// offsets and the request FSM encoding.
package asp_irq_ctrl_pkg;

    localparam int BSP_NUM_INTERRUPT_LINES = 4;
    localparam int BSP_AVMM_NUM_IRQ_USED   = 3;
    localparam int BSP_DMA_0_IRQ_BIT       = 0;
    localparam int BSP_KERNEL_IRQ_BIT      = 1;
    localparam int BSP_DMA_1_IRQ_BIT       = 2;

    localparam int IRQ_CSR_STATUS  = 0;
    localparam int IRQ_CSR_MASK    = 1;
    localparam int IRQ_CSR_PENDING = 2;
    localparam int IRQ_CSR_FORCE   = 3;
    localparam int IRQ_CSR_COUNT   = 4;

    localparam int IRQ_STATUS_RAW_LSB   = 16;
    localparam int IRQ_STATUS_VALID_BIT = 32;

    typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_GAP} irq_fsm_t;

endpackage

// File: rtl/asp_irq_ctrl_if.sv
// CSR slave bus and host interrupt-request handshake of the ASP interrupt
// aggregator; slave is the aggregator side, master the host side.
interface asp_irq_ctrl_if #(
    parameter int CSR_DATA_W = 64,
    parameter int CSR_ADDR_W = 3,
    parameter int VEC_W      = 2
);
    logic [CSR_ADDR_W-1:0] csr_address;
    logic                  csr_read;
    logic                  csr_write;
    logic [CSR_DATA_W-1:0] csr_writedata;
    logic [7:0]            csr_byteenable;
    logic [CSR_DATA_W-1:0] csr_readdata;
    logic                  csr_readdatavalid;
    logic                  csr_waitrequest;
    logic                  irq_req_valid;
    logic [VEC_W-1:0]      irq_req_vector;
    logic                  irq_req_ready;

    modport slave (
        input  csr_address, csr_read, csr_write, csr_writedata, csr_byteenable,
        input  irq_req_ready,
        output csr_readdata, csr_readdatavalid, csr_waitrequest,
        output irq_req_valid, irq_req_vector
    );

    modport master (
        output csr_address, csr_read, csr_write, csr_writedata, csr_byteenable,
        output irq_req_ready,
        input  csr_readdata, csr_readdatavalid, csr_waitrequest,
        input  irq_req_valid, irq_req_vector
    );
endinterface

// File: rtl/asp_irq_rr_arb.sv
// Combinational round-robin pick: first set request bit searching upward from
// last_grant+1, wrapping, so the previous winner has the lowest priority.
module asp_irq_rr_arb #(
    parameter int NUM_LINES = 4,
    parameter int VEC_W     = $clog2(NUM_LINES)
) (
    input  logic [NUM_LINES-1:0] req,
    input  logic [VEC_W-1:0]     last_grant,
    output logic [NUM_LINES-1:0] grant_oh,
    output logic [VEC_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [VEC_W-1:0] cand;

    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NUM_LINES; off++) begin
            cand = VEC_W'((int'(last_grant) + off) % NUM_LINES);
            if (!grant_valid && req[cand]) begin
                grant_valid    = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt aggregator: edge-detects source lines into pending bits and
// issues unmasked ones round-robin, one at a time, on a valid/ready port.
module asp_irq_ctrl
    import asp_irq_ctrl_pkg::*;
#(
    parameter int NUM_LINES  = BSP_NUM_INTERRUPT_LINES,
    parameter int NUM_USED   = BSP_AVMM_NUM_IRQ_USED,
    parameter int CSR_DATA_W = 64,
    parameter int CSR_ADDR_W = 3,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_LINES-1:0] irq_in,
    asp_irq_ctrl_if.slave        bus
);

    localparam int VEC_W = $clog2(NUM_LINES);
    localparam logic [NUM_LINES-1:0] USED_MASK = NUM_LINES'((64'd1 << NUM_USED) - 64'd1);

    irq_fsm_t              state, state_nxt;
    logic [NUM_LINES-1:0]  irq_d, pending, mask, rise, set_bits, clr_bits, eligible;
    logic [NUM_LINES-1:0]  grant_oh, req_oh, wr_bits;
    logic [VEC_W-1:0]      grant_idx, vector, last_grant;
    logic                  grant_valid, req_valid, accept, grant_load;
    logic                  wr_mask, wr_pend, wr_force;
    logic [CNT_W-1:0]      count;
    logic [CSR_DATA_W-1:0] byte_bits, rd_word, rdata;
    logic                  rdv;
    logic                  unused_ok;

    for (genvar b = 0; b < CSR_DATA_W / 8; b++) begin : g_be
        assign byte_bits[b*8 +: 8] = {8{bus.csr_byteenable[b]}};
    end

    assign wr_bits  = bus.csr_writedata[NUM_LINES-1:0] & byte_bits[NUM_LINES-1:0];
    assign wr_mask  = bus.csr_write && (bus.csr_address == CSR_ADDR_W'(IRQ_CSR_MASK));
    assign wr_pend  = bus.csr_write && (bus.csr_address == CSR_ADDR_W'(IRQ_CSR_PENDING));
    assign wr_force = bus.csr_write && (bus.csr_address == CSR_ADDR_W'(IRQ_CSR_FORCE));

    // A set in the same cycle as a clear of the same bit must win, so no edge is lost.
    assign rise     = irq_in & ~irq_d & USED_MASK;
    assign set_bits = rise | (wr_force ? wr_bits : '0);
    assign clr_bits = (wr_pend ? wr_bits : '0) | (accept ? req_oh : '0);
    assign eligible = pending & ~mask;

    asp_irq_rr_arb #(
        .NUM_LINES (NUM_LINES),
        .VEC_W     (VEC_W)
    ) u_arb (
        .req         (eligible),
        .last_grant  (last_grant),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_d   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            irq_d   <= irq_in;
            pending <= ((pending & ~clr_bits) | set_bits) & USED_MASK;
            if (wr_mask) begin
                mask <= ((mask & ~byte_bits[NUM_LINES-1:0]) | wr_bits) & USED_MASK;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IRQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IRQ_IDLE: if (grant_valid) state_nxt = IRQ_REQ;
            IRQ_REQ:  if (bus.irq_req_ready) state_nxt = IRQ_GAP;
            IRQ_GAP:  state_nxt = IRQ_IDLE;
            default:  state_nxt = IRQ_IDLE;
        endcase
    end

    always_comb begin
        req_valid  = (state == IRQ_REQ);
        accept     = req_valid && bus.irq_req_ready;
        grant_load = (state == IRQ_IDLE) && grant_valid;
    end

    // Vector and its one-hot stay frozen for the whole REQ phase regardless of mask/pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vector     <= '0;
            req_oh     <= '0;
            last_grant <= VEC_W'(NUM_LINES - 1);
            count      <= '0;
        end else begin
            if (grant_load) begin
                vector <= grant_idx;
                req_oh <= grant_oh;
            end
            if (accept) begin
                last_grant <= vector;
                count      <= count + 1'b1;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (bus.csr_address)
            CSR_ADDR_W'(IRQ_CSR_STATUS): begin
                rd_word[NUM_LINES-1:0]                     = pending;
                rd_word[IRQ_STATUS_RAW_LSB +: NUM_LINES]   = irq_in;
                rd_word[IRQ_STATUS_VALID_BIT]              = req_valid;
            end
            CSR_ADDR_W'(IRQ_CSR_MASK):    rd_word[NUM_LINES-1:0] = mask;
            CSR_ADDR_W'(IRQ_CSR_PENDING): rd_word[NUM_LINES-1:0] = pending;
            CSR_ADDR_W'(IRQ_CSR_COUNT):   rd_word[CNT_W-1:0]     = count;
            default:                      rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdv   <= 1'b0;
            rdata <= '0;
        end else begin
            rdv   <= bus.csr_read;
            rdata <= bus.csr_read ? rd_word : '0;
        end
    end

    assign bus.csr_readdata      = rdata;
    assign bus.csr_readdatavalid = rdv;
    assign bus.csr_waitrequest   = 1'b0;
    assign bus.irq_req_valid     = req_valid;
    assign bus.irq_req_vector    = vector;

    assign unused_ok = ^{bus.csr_writedata[CSR_DATA_W-1:NUM_LINES], byte_bits[CSR_DATA_W-1:NUM_LINES]};

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Bench for asp_irq_ctrl: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a behavioural model of the aggregator.
module tb_asp_irq_ctrl;
    import asp_irq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] irq = '0;

    asp_irq_ctrl_if #(.CSR_DATA_W(64), .CSR_ADDR_W(3), .VEC_W(2)) bus ();

    asp_irq_ctrl #(
        .NUM_LINES  (4),
        .NUM_USED   (3),
        .CSR_DATA_W (64),
        .CSR_ADDR_W (3),
        .CNT_W      (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq_in  (irq),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_vec[$];
    int acc_cyc[$];

    // Behavioural model: pending/mask as bit sets, issue port as valid + vector
    // with a cooldown counter after each acceptance.
    logic [3:0]  m_pend, m_mask, m_prev;
    logic [31:0] m_count;
    logic        m_valid, m_rdv;
    int          m_vec, m_last, m_gap;
    logic [63:0] m_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_count = '0;
        m_valid = 1'b0; m_vec = 0; m_last = 3; m_gap = 0;
        m_rdv = 1'b0; m_rdata = '0;
    endtask

    function automatic logic [63:0] m_csr_value(input int a);
        logic [63:0] v;
        v = '0;
        case (a)
            IRQ_CSR_STATUS: begin
                v[3:0] = m_pend; v[19:16] = irq; v[32] = m_valid;
            end
            IRQ_CSR_MASK:    v[3:0]  = m_mask;
            IRQ_CSR_PENDING: v[3:0]  = m_pend;
            IRQ_CSR_COUNT:   v[31:0] = m_count;
            default:         v = '0;
        endcase
        return v;
    endfunction

    task automatic model_step();
        int          a;
        logic [3:0]  wd, np, nm;
        logic        acc, rise, frc, clr;
        logic [63:0] nrd;
        a   = int'(bus.csr_address);
        wd  = bus.csr_byteenable[0] ? bus.csr_writedata[3:0] : 4'h0;
        acc = m_valid && bus.irq_req_ready;
        nrd = bus.csr_read ? m_csr_value(a) : 64'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= 3) begin
                np[i] = 1'b0;
            end else begin
                rise  = irq[i] && !m_prev[i];
                frc   = bus.csr_write && a == IRQ_CSR_FORCE && wd[i];
                clr   = (bus.csr_write && a == IRQ_CSR_PENDING && wd[i]) || (acc && m_vec == i);
                np[i] = (rise || frc) ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
            end
        end
        nm = (bus.csr_write && a == IRQ_CSR_MASK && bus.csr_byteenable[0]) ? (wd & 4'h7) : m_mask;
        if (m_valid) begin
            if (acc) begin
                m_valid = 1'b0; m_last = m_vec; m_gap = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int c = (m_last + k) % 4;
                if (!m_valid && m_pend[c] && !m_mask[c]) begin
                    m_valid = 1'b1; m_vec = c;
                end
            end
        end
        if (acc) m_count++;
        m_pend = np; m_mask = nm; m_prev = irq;
        m_rdv = bus.csr_read; m_rdata = nrd;
    endtask

    task automatic tick();
        if (bus.irq_req_valid && bus.irq_req_ready) begin
            acc_vec.push_back(int'(bus.irq_req_vector));
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        cyc++;
        @(negedge clk);
        chk("valid", bus.irq_req_valid, m_valid);
        if (m_valid) chk("vector", bus.irq_req_vector, m_vec);
        chk("rdvalid", bus.csr_readdatavalid, m_rdv);
        if (m_rdv) chk("rdata", bus.csr_readdata, m_rdata);
        chk("waitreq", bus.csr_waitrequest, 1'b0);
    endtask

    task automatic csr_write(input int a, input logic [63:0] d, input logic [7:0] be);
        bus.csr_address = 3'(a); bus.csr_writedata = d; bus.csr_byteenable = be;
        bus.csr_write = 1'b1;
        tick();
        bus.csr_write = 1'b0;
    endtask

    task automatic csr_read(input int a, output logic [63:0] d);
        bus.csr_address = 3'(a); bus.csr_read = 1'b1;
        tick();
        bus.csr_read = 1'b0;
        d = bus.csr_readdata;
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!bus.irq_req_valid && n < limit) begin
            tick(); n++;
        end
        chk("wait_valid", bus.irq_req_valid, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; irq = '0; bus.irq_req_ready = 1'b0;
        bus.csr_read = 1'b0; bus.csr_write = 1'b0;
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        acc_vec.delete(); acc_cyc.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        bus.csr_address = '0; bus.csr_read = 1'b0; bus.csr_write = 1'b0;
        bus.csr_writedata = '0; bus.csr_byteenable = '0; bus.irq_req_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        chk("rst_valid", bus.irq_req_valid, 1'b0);
        csr_read(IRQ_CSR_STATUS, d); chk("rst_status", d, 64'h0);
        csr_read(IRQ_CSR_COUNT, d);  chk("rst_count", d, 64'h0);
        csr_read(IRQ_CSR_MASK, d);   chk("rst_mask", d, 64'h0);

        // single kernel edge, latency and held request
        irq[1] = 1'b1;
        tick(); chk("se_lat1_valid", bus.irq_req_valid, 1'b0);
        tick(); chk("se_lat2_valid", bus.irq_req_valid, 1'b1);
        chk("se_vec", bus.irq_req_vector, 2'd1);
        repeat (5) begin
            tick();
            chk("se_hold_valid", bus.irq_req_valid, 1'b1);
            chk("se_hold_vec", bus.irq_req_vector, 2'd1);
        end
        bus.irq_req_ready = 1'b1; tick(); bus.irq_req_ready = 1'b0;
        chk("se_gap_valid", bus.irq_req_valid, 1'b0);
        csr_read(IRQ_CSR_STATUS, d); chk("se_pend1", d[1], 1'b0);
        csr_read(IRQ_CSR_COUNT, d);  chk("se_count", d, 64'd1);

        // round robin from reset
        do_reset();
        bus.irq_req_ready = 1'b1; irq = 4'b0111;
        repeat (14) tick();
        chk("rr_n", acc_vec.size(), 3);
        if (acc_vec.size() >= 3) begin
            chk("rr_v0", acc_vec[0], 0); chk("rr_v1", acc_vec[1], 1); chk("rr_v2", acc_vec[2], 2);
            chk("rr_gap01", acc_cyc[1] - acc_cyc[0], 3);
            chk("rr_gap12", acc_cyc[2] - acc_cyc[1], 3);
        end
        csr_read(IRQ_CSR_COUNT, d); chk("rr_count", d, 64'd3);
        irq[0] = 1'b0; tick(); irq[0] = 1'b1;
        repeat (6) tick();
        chk("rr_again_n", acc_vec.size(), 4);
        if (acc_vec.size() >= 4) chk("rr_again_vec", acc_vec[3], 0);

        // mask behaviour
        do_reset();
        bus.irq_req_ready = 1'b1;
        csr_write(IRQ_CSR_MASK, 64'h1, 8'hff);
        irq[0] = 1'b1;
        repeat (4) tick();
        csr_read(IRQ_CSR_STATUS, d); chk("mask_pend0", d[0], 1'b1);
        chk("mask_noreq", bus.irq_req_valid, 1'b0);
        csr_write(IRQ_CSR_MASK, 64'h0, 8'hff);
        wait_valid(10); chk("mask_vec", bus.irq_req_vector, 2'd0);
        tick();
        irq[0] = 1'b0; tick();
        csr_write(IRQ_CSR_MASK, 64'h1, 8'hff);
        irq[0] = 1'b1; repeat (3) tick();
        csr_write(IRQ_CSR_PENDING, 64'h1, 8'hff);
        csr_read(IRQ_CSR_STATUS, d); chk("w1c_pend0", d[0], 1'b0);
        csr_write(IRQ_CSR_MASK, 64'h0, 8'hff);
        repeat (4) tick(); chk("w1c_noreq", bus.irq_req_valid, 1'b0);

        // set-vs-clear collisions
        do_reset();
        csr_write(IRQ_CSR_FORCE, 64'h4, 8'hff);
        wait_valid(10); chk("col_vec", bus.irq_req_vector, 2'd2);
        irq[2] = 1'b1; bus.irq_req_ready = 1'b1;
        tick(); bus.irq_req_ready = 1'b0;
        csr_read(IRQ_CSR_STATUS, d); chk("col_pend2", d[2], 1'b1);
        wait_valid(10); chk("col_vec2", bus.irq_req_vector, 2'd2);
        bus.irq_req_ready = 1'b1; tick(); bus.irq_req_ready = 1'b0;
        irq[0] = 1'b1;
        csr_write(IRQ_CSR_PENDING, 64'h1, 8'hff);
        csr_read(IRQ_CSR_STATUS, d); chk("col_w1c_pend0", d[0], 1'b1);
        bus.irq_req_ready = 1'b1; repeat (6) tick(); bus.irq_req_ready = 1'b0;

        // unused line 3
        do_reset();
        csr_write(IRQ_CSR_FORCE, 64'h8, 8'hff);
        irq[3] = 1'b1; repeat (4) tick();
        csr_read(IRQ_CSR_STATUS, d);
        chk("unused_pend3", d[3], 1'b0); chk("unused_raw3", d[19], 1'b1);
        chk("unused_noreq", bus.irq_req_valid, 1'b0);
        csr_write(IRQ_CSR_MASK, 64'hf, 8'hff);
        csr_read(IRQ_CSR_MASK, d); chk("unused_mask", d, 64'h7);
        csr_write(IRQ_CSR_MASK, 64'h0, 8'hff);

        // reset while a request is outstanding
        do_reset();
        csr_write(IRQ_CSR_FORCE, 64'h2, 8'hff);
        wait_valid(10);
        reset_n = 1'b0; #1;
        chk("rst_mid_valid", bus.irq_req_valid, 1'b0);
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        csr_read(IRQ_CSR_STATUS, d); chk("rst_mid_status", d, 64'h0);
        csr_read(IRQ_CSR_COUNT, d);  chk("rst_mid_count", d, 64'h0);
        repeat (10) begin
            tick(); chk("rst_mid_quiet", bus.irq_req_valid, 1'b0);
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            bus.irq_req_ready = 1'($urandom_range(0, 1));
            bus.csr_read      = ($urandom_range(0, 3) == 0);
            bus.csr_write     = ($urandom_range(0, 5) == 0);
            bus.csr_address   = 3'($urandom_range(0, 7));
            bus.csr_writedata = {$urandom, $urandom};
            bus.csr_byteenable = 8'($urandom_range(0, 255));
            tick();
        end
        bus.csr_read = 1'b0; bus.csr_write = 1'b0; bus.irq_req_ready = 1'b1;
        repeat (20) tick();
        csr_read(IRQ_CSR_COUNT, d); chk("rand_count", d, {32'h0, m_count});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
